sparce_sasa_table_assoc: RTL and testbench
==========================================

Name: sparce_sasa_table_assoc

Overview:
- Next-generation SparCE SASA table: a fully associative, N-entry skip-rule store.
- Entries are configured over a memory-mapped write path using a two-write staging protocol (PC word, then info word).
- Lookup is by fetch PC with a registered, 1-cycle-latency result feeding the PSRU.
- Beyond the single-entry table it replaces: configurable depth, skip-count width and base address; duplicate-PC overwrite; round-robin replacement when full; clear-all; occupancy and error status.

Parameters:
- NUM_ENTRIES, 16, number of table entries (power of 2, range 2..64).
- SKIP_W, 16, width of insts_to_skip (range 1..16).
- SASA_BASE, 32'h0000_1000, base address of the 3-word config window.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- pc  input  32  PC to look up (preceding-instruction address).
- sasa_addr  input  32  config write address.
- sasa_data  input  32  config write data.
- sasa_wen  input  1  config write strobe, one write per cycle when high.
- valid  output  1  registered lookup hit.
- sasa_rs1  output  5  hit entry source register 1.
- sasa_rs2  output  5  hit entry source register 2.
- condition  output  1  hit entry condition (0 = OR, 1 = AND).
- insts_to_skip  output  SKIP_W  hit entry skip count.
- preceding_pc  output  32  hit entry PC.
- sasa_enable  output  1  current table enable bit.
- num_valid  output  $clog2(NUM_ENTRIES)+1  count of valid entries.
- cfg_error  output  1  one-cycle pulse on a protocol error.

Behaviour:
- Reset: every output is 0, every entry valid bit is 0, the victim pointer is 0, the FSM is in IDLE and the staged PC is 0.
- Config window: a write is accepted only when sasa_wen=1 and sasa_addr equals one of the three window addresses below. Writes to any other address are ignored with no error.
- SASA_BASE+0 (CTRL):
  - bit0 sets sasa_enable, effective on the next cycle.
  - bit1=1 performs clear-all: all valid bits cleared, victim pointer to 0, FSM to IDLE. Takes effect at the clock edge.
  - All other bits are ignored.
- SASA_BASE+4 (PC): stage sasa_data as the staged PC and move the FSM to STAGED. A second PC write while in STAGED replaces the staged PC with no error.
- SASA_BASE+8 (INFO) field layout: [4:0]=rs1, [9:5]=rs2, [10]=cond, [31:16]=skip (low SKIP_W bits used).
- SASA_BASE+8 (INFO), FSM in STAGED: commit the entry and return to IDLE.
- SASA_BASE+8 (INFO), FSM in IDLE: no table change; cfg_error pulses 1 on the next cycle.
- Commit slot selection, by priority:
  - (a) a valid entry whose PC equals the staged PC is overwritten in place;
  - (b) otherwise the lowest-index invalid entry is used;
  - (c) otherwise (table full) the entry at the victim pointer is used, and the pointer increments modulo NUM_ENTRIES.
  - The victim pointer changes only in case (c) or on clear-all.
- FSM: two states, IDLE and STAGED.
  - IDLE to STAGED on a PC write.
  - STAGED to IDLE on an INFO write or clear-all.
  - No timeout.
- Lookup:
  - Combinational match of pc against all valid entries; outputs registered, so a result appears 1 cycle after pc is presented.
  - valid = sasa_enable AND a match exists.
  - On a miss or when disabled, valid=0 and all field outputs are 0.
  - Only one entry can match, because duplicates are prevented by rule (a).
- Simultaneous events:
  - A lookup in the same cycle as a commit or clear sees the pre-write table; the new contents are visible from the following cycle's lookup.
  - A CTRL enable change in the same cycle as a lookup: the registered valid uses the old enable value.
- num_valid is registered and updates the cycle after a commit into an invalid slot (+1) or a clear-all (to 0). An overwrite or replacement leaves it unchanged.
- Reset asserted mid-protocol (STAGED): the staged PC is discarded, the FSM goes to IDLE and all state is reset asynchronously.

Test Plan:
- Reset, then write CTRL=1, PC=0x100, INFO=0x0005_0443 (rs1=3, rs2=2, cond=1, skip=5). Present pc=0x100 → next cycle valid=1, rs1=3, rs2=2, condition=1, insts_to_skip=5, preceding_pc=0x100, num_valid=1.
- With sasa_enable=0, load an entry at 0x200 and look up 0x200 → valid=0. Write CTRL=1, look up again → valid=1.
- Write INFO with no PC staged → cfg_error=1 for exactly one cycle, num_valid unchanged. Then write PC=0x300, PC=0x304, INFO → entry stored at 0x304, a lookup of 0x300 misses.
- Fill 16 entries (PCs 0x0..0x3C). Add 0x40 → it replaces entry 0 and a lookup of 0x0 misses. Add 0x44 → it replaces entry 1. num_valid stays 16 throughout.
- Rewrite PC=0x8 with new INFO skip=9 → lookup returns skip=9 and num_valid is unchanged. Write CTRL bit1 → num_valid=0 and all lookups miss.
- Assert RST while in STAGED, release, then write INFO → cfg_error pulses and there is no commit. Present a lookup in the same cycle as a commit → old data (a miss) is returned.

Source files
------------

// File: rtl/sparce_sasa_table_assoc.sv
// sparce_sasa_table_assoc: fully associative SASA skip-rule table with staged config writes and registered lookup
module sparce_sasa_table_assoc #(
    parameter int          NUM_ENTRIES = 16,
    parameter int          SKIP_W      = 16,
    parameter logic [31:0] SASA_BASE   = 32'h0000_1000
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [31:0]                    pc,
    input  logic [31:0]                    sasa_addr,
    input  logic [31:0]                    sasa_data,
    input  logic                           sasa_wen,
    output logic                           valid,
    output logic [4:0]                     sasa_rs1,
    output logic [4:0]                     sasa_rs2,
    output logic                           condition,
    output logic [SKIP_W-1:0]              insts_to_skip,
    output logic [31:0]                    preceding_pc,
    output logic                           sasa_enable,
    output logic [$clog2(NUM_ENTRIES):0]   num_valid,
    output logic                           cfg_error
);
    localparam int IW = $clog2(NUM_ENTRIES);
    localparam int NW = IW + 1;

    typedef enum logic {IDLE, STAGED} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             staged_pc;
    logic [IW-1:0]           victim;
    logic [NUM_ENTRIES-1:0]  ent_valid;
    logic [31:0]             ent_pc   [NUM_ENTRIES];
    logic [4:0]              ent_rs1  [NUM_ENTRIES];
    logic [4:0]              ent_rs2  [NUM_ENTRIES];
    logic                    ent_cond [NUM_ENTRIES];
    logic [SKIP_W-1:0]       ent_skip [NUM_ENTRIES];

    logic ctrl_wr, pc_wr, info_wr, clear, commit;
    logic dup_hit, free_hit;
    logic [IW-1:0] dup_idx, free_idx, slot;
    logic hit;
    logic [4:0] hit_rs1, hit_rs2;
    logic hit_cond;
    logic [SKIP_W-1:0] hit_skip;
    logic [31:0] hit_pc;

    assign ctrl_wr = sasa_wen && sasa_addr == SASA_BASE;
    assign pc_wr   = sasa_wen && sasa_addr == SASA_BASE + 32'd4;
    assign info_wr = sasa_wen && sasa_addr == SASA_BASE + 32'd8;
    assign clear   = ctrl_wr && sasa_data[1];
    assign commit  = info_wr && state_q == STAGED;
    assign slot    = dup_hit ? dup_idx : free_hit ? free_idx : victim;

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: PC write stages, INFO write or clear returns to idle
    always_comb begin
        state_d = state_q;
        if (clear)        state_d = IDLE;
        else if (pc_wr)   state_d = STAGED;
        else if (info_wr) state_d = IDLE;
    end

    // Commit slot search: existing PC first, then lowest free slot (descending scan leaves the lowest)
    always_comb begin
        dup_hit  = 1'b0;
        dup_idx  = '0;
        free_hit = 1'b0;
        free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (ent_valid[i] && ent_pc[i] == staged_pc) begin
                dup_hit = 1'b1;
                dup_idx = IW'(i);
            end
            if (!ent_valid[i]) begin
                free_hit = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    // Lookup match; duplicates are never stored, so OR-merging the fields selects the single hit
    always_comb begin
        hit      = 1'b0;
        hit_rs1  = '0;
        hit_rs2  = '0;
        hit_cond = 1'b0;
        hit_skip = '0;
        hit_pc   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (ent_valid[i] && ent_pc[i] == pc) begin
                hit      = 1'b1;
                hit_rs1  = hit_rs1 | ent_rs1[i];
                hit_rs2  = hit_rs2 | ent_rs2[i];
                hit_cond = hit_cond | ent_cond[i];
                hit_skip = hit_skip | ent_skip[i];
                hit_pc   = hit_pc | ent_pc[i];
            end
        end
    end

    // Control state: enable, staged PC, valid bits, victim pointer, occupancy, error pulse
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sasa_enable <= 1'b0;
            staged_pc   <= '0;
            ent_valid   <= '0;
            victim      <= '0;
            num_valid   <= '0;
            cfg_error   <= 1'b0;
        end else begin
            cfg_error <= info_wr && state_q == IDLE;
            if (ctrl_wr) sasa_enable <= sasa_data[0];
            if (pc_wr) staged_pc <= sasa_data;
            if (clear) begin
                ent_valid <= '0;
                victim    <= '0;
                num_valid <= '0;
            end else if (commit) begin
                ent_valid[slot] <= 1'b1;
                if (!dup_hit && free_hit) num_valid <= num_valid + NW'(1);
                if (!dup_hit && !free_hit) victim <= victim + IW'(1);
            end
        end
    end

    // Entry payload storage; meaningful only where the valid bit is set
    always_ff @(posedge CLK) begin
        if (commit) begin
            ent_pc[slot]   <= staged_pc;
            ent_rs1[slot]  <= sasa_data[4:0];
            ent_rs2[slot]  <= sasa_data[9:5];
            ent_cond[slot] <= sasa_data[10];
            ent_skip[slot] <= sasa_data[16 +: SKIP_W];
        end
    end

    // Registered lookup result using the pre-write table and the current enable
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid         <= 1'b0;
            sasa_rs1      <= '0;
            sasa_rs2      <= '0;
            condition     <= 1'b0;
            insts_to_skip <= '0;
            preceding_pc  <= '0;
        end else begin
            valid         <= sasa_enable && hit;
            sasa_rs1      <= sasa_enable ? hit_rs1 : '0;
            sasa_rs2      <= sasa_enable ? hit_rs2 : '0;
            condition     <= sasa_enable && hit_cond;
            insts_to_skip <= sasa_enable ? hit_skip : '0;
            preceding_pc  <= sasa_enable ? hit_pc : '0;
        end
    end
endmodule

// File: tb/tb_sparce_sasa_table_assoc.sv
// tb_sparce_sasa_table_assoc: randomized bench against an entry-list reference model
module tb_sparce_sasa_table_assoc;
    localparam int          N = 16;
    localparam logic [31:0] B = 32'h0000_1000;

    logic        CLK = 1'b0, RST = 1'b0;
    logic [31:0] pc = '0, sasa_addr = '0, sasa_data = '0;
    logic        sasa_wen = 1'b0;
    logic        valid, condition, sasa_enable, cfg_error;
    logic [4:0]  sasa_rs1, sasa_rs2;
    logic [15:0] insts_to_skip;
    logic [31:0] preceding_pc;
    logic [4:0]  num_valid;

    sparce_sasa_table_assoc dut (
        .CLK(CLK), .RST(RST), .pc(pc), .sasa_addr(sasa_addr), .sasa_data(sasa_data),
        .sasa_wen(sasa_wen), .valid(valid), .sasa_rs1(sasa_rs1), .sasa_rs2(sasa_rs2),
        .condition(condition), .insts_to_skip(insts_to_skip), .preceding_pc(preceding_pc),
        .sasa_enable(sasa_enable), .num_valid(num_valid), .cfg_error(cfg_error)
    );

    always #5 CLK = ~CLK;

    int checks = 0, failures = 0;

    bit          m_v   [N];
    logic [31:0] m_pc  [N];
    logic [31:0] m_inf [N];
    bit          m_en, m_stg;
    logic [31:0] m_spc;
    int          m_vic;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int find(input logic [31:0] p);
        for (int i = 0; i < N; i++) if (m_v[i] && m_pc[i] == p) return i;
        return -1;
    endfunction

    function automatic int occupancy();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_v[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_v[i] = 0;
        m_en = 0; m_stg = 0; m_spc = '0; m_vic = 0;
    endtask

    task automatic step(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
        int k, s;
        bit hit;
        logic [31:0] inf, e_pc;
        bit e_err;
        sasa_wen = w; sasa_addr = a; sasa_data = d; pc = p;
        k = find(p);
        hit = m_en && k >= 0;
        inf = hit ? m_inf[k < 0 ? 0 : k] : '0;
        e_pc = hit ? p : '0;
        e_err = w && a == B + 32'd8 && !m_stg;
        if (w && a == B) begin
            m_en = d[0];
            if (d[1]) begin
                for (int i = 0; i < N; i++) m_v[i] = 0;
                m_vic = 0; m_stg = 0;
            end
        end else if (w && a == B + 32'd4) begin
            m_stg = 1; m_spc = d;
        end else if (w && a == B + 32'd8 && m_stg) begin
            s = find(m_spc);
            if (s < 0) for (int i = N - 1; i >= 0; i--) if (!m_v[i]) s = i;
            if (s < 0) begin
                s = m_vic;
                m_vic = (m_vic + 1) % N;
            end
            m_v[s] = 1; m_pc[s] = m_spc; m_inf[s] = d;
            m_stg = 0;
        end
        @(posedge CLK); #1;
        chk("valid", 32'(valid), 32'(hit));
        chk("rs1", 32'(sasa_rs1), 32'(inf[4:0]));
        chk("rs2", 32'(sasa_rs2), 32'(inf[9:5]));
        chk("cond", 32'(condition), 32'(inf[10]));
        chk("skip", 32'(insts_to_skip), 32'(inf[31:16]));
        chk("prev_pc", preceding_pc, e_pc);
        chk("enable", 32'(sasa_enable), 32'(m_en));
        chk("num_valid", 32'(num_valid), 32'(occupancy()));
        chk("cfg_error", 32'(cfg_error), 32'(e_err));
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(1, a, d, 32'h0);
    endtask

    task automatic look(input logic [31:0] p);
        step(0, 32'h0, 32'h0, p);
    endtask

    task automatic rst_pulse();
        sasa_wen = 0;
        #2 RST = 1;
        #1;
        chk("rst_valid", 32'(valid), 0);
        chk("rst_fields", 32'(sasa_rs1) | 32'(sasa_rs2) | 32'(condition) | 32'(insts_to_skip), 0);
        chk("rst_prev_pc", preceding_pc, 0);
        chk("rst_enable", 32'(sasa_enable), 0);
        chk("rst_num_valid", 32'(num_valid), 0);
        chk("rst_cfg_error", 32'(cfg_error), 0);
        model_reset();
        #10 RST = 0;
        @(posedge CLK); #1;
    endtask

    initial begin
        model_reset();
        @(posedge CLK); #1;
        rst_pulse();

        wr(B, 1); wr(B + 4, 32'h100); wr(B + 8, 32'h0005_0443);
        look(32'h100);
        chk("tp1_valid", 32'(valid), 1);
        chk("tp1_rs1", 32'(sasa_rs1), 3);
        chk("tp1_rs2", 32'(sasa_rs2), 2);
        chk("tp1_cond", 32'(condition), 1);
        chk("tp1_skip", 32'(insts_to_skip), 5);
        chk("tp1_prev_pc", preceding_pc, 32'h100);
        chk("tp1_num", 32'(num_valid), 1);

        wr(B, 0); wr(B + 4, 32'h200); wr(B + 8, 32'h0003_0021);
        look(32'h200); chk("dis_miss", 32'(valid), 0);
        wr(B, 1);
        look(32'h200); chk("en_hit", 32'(valid), 1);

        wr(B + 8, 32'h1234);
        chk("err_pulse", 32'(cfg_error), 1);
        chk("err_num", 32'(num_valid), 2);
        look(32'h0); chk("err_once", 32'(cfg_error), 0);
        wr(B + 4, 32'h300); wr(B + 4, 32'h304); wr(B + 8, 32'h0002_0001);
        look(32'h300); chk("restage_miss", 32'(valid), 0);
        look(32'h304); chk("restage_hit", 32'(valid), 1);

        wr(B, 3);
        for (int i = 0; i < N; i++) begin
            wr(B + 4, 32'(i * 4));
            wr(B + 8, $urandom);
        end
        chk("full_num", 32'(num_valid), 16);
        wr(B + 4, 32'h40); wr(B + 8, 32'h0001_0000);
        look(32'h0);  chk("evict0", 32'(valid), 0);
        look(32'h40); chk("new40", 32'(valid), 1);
        wr(B + 4, 32'h44); wr(B + 8, 32'h0001_0000);
        look(32'h4);  chk("evict1", 32'(valid), 0);
        chk("full_num2", 32'(num_valid), 16);

        wr(B + 4, 32'h8); wr(B + 8, 32'h0009_0000);
        look(32'h8);
        chk("ovw_skip", 32'(insts_to_skip), 9);
        chk("ovw_num", 32'(num_valid), 16);
        wr(B, 3);
        chk("clr_num", 32'(num_valid), 0);
        look(32'h8); chk("clr_miss", 32'(valid), 0);

        wr(B + 4, 32'h500);
        rst_pulse();
        wr(B + 8, 32'h1);
        chk("rst_stg_err", 32'(cfg_error), 1);
        chk("rst_stg_num", 32'(num_valid), 0);
        wr(B, 1); wr(B + 4, 32'h600);
        step(1, B + 8, 32'h0007_0000, 32'h600);
        chk("same_cycle_old", 32'(valid), 0);
        look(32'h600); chk("next_cycle_new", 32'(valid), 1);

        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [31:0] a, d;
            r = $urandom_range(0, 9);
            a = r == 0 ? B : r < 5 ? B + 32'd4 : r < 9 ? B + 32'd8 : B + 32'd12;
            d = r == 0 ? (($urandom_range(0, 15) == 0 ? 32'd2 : 32'd0) | ($urandom_range(0, 3) != 0 ? 32'd1 : 32'd0))
              : r < 5 ? 32'($urandom_range(0, 31) * 4) : $urandom;
            if (i == 1500) rst_pulse();
            step($urandom_range(0, 4) != 0, a, d, 32'($urandom_range(0, 31) * 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
